exp_in_conditioner: RTL and testbench

- Input conditioner for the expansion-connector P/N pins; sits directly upstream of the housekeeping block.
- Synchronises and debounces the raw pad inputs, then drives the clean values into the housekeeping expansion-data inputs.
- Adds per-pin rising/falling edge capture with sticky status and an interrupt.
- Adds one selectable rising-edge event counter, all exposed on its own system-bus register window.

---
 rtl/exp_in_conditioner.sv | 208 ++++++++++++++++++++
 tb/tb_exp_in_conditioner.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exp_in_conditioner.sv
// exp_in_conditioner
//   Conditions the expansion-connector P/N pad inputs before they reach the housekeeping
//   block. Each pin is synchronised (two flops), debounced against a programmable
//   threshold, then watched for rising/falling edges that set sticky status bits and
//   raise a level interrupt. One pin, chosen by CNT_SEL, also drives a saturating
//   32-bit rising-edge event counter. All control and status is on a small bus window.
//
// Ports
//   clk_i      clock
//   rstn_i     synchronous active-low reset
//   pin_i      raw pad inputs [DW-1:0]=P, [2*DW-1:DW]=N (asynchronous)
//   pin_o      debounced pin state (P half -> exp_p_dat_i, N half -> exp_n_dat_i)
//   irq_o      level interrupt, high while any sticky status bit is set
//   sys_addr   bus address, decoded on [19:0]
//   sys_wdata  bus write data
//   sys_wen    bus write enable
//   sys_ren    bus read enable
//   sys_rdata  bus read data (registered)
//   sys_err    bus error, always 0
//   sys_ack    bus acknowledge, one cycle after any request
//
// Register map (sys_addr[19:0])
//   0x00 DEB_THR rw   0x04 RISE_EN rw   0x08 FALL_EN rw   0x0C RSTS r/W1C
//   0x10 FSTS r/W1C   0x14 STATE r      0x18 CNT_SEL rw   0x1C EVT r, write clears

module exp_in_conditioner #(
   parameter int unsigned DW  = 8,
   parameter int unsigned DBW = 16,
   parameter int unsigned SW  = 4
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic [2*DW-1:0] pin_i,
   output logic [2*DW-1:0] pin_o,
   output logic            irq_o,
   input  logic [31:0]     sys_addr,
   input  logic [31:0]     sys_wdata,
   input  logic            sys_wen,
   input  logic            sys_ren,
   output logic [31:0]     sys_rdata,
   output logic            sys_err,
   output logic            sys_ack
);

   localparam int unsigned NP = 2 * DW;

   localparam logic [19:0] AddrDebThr = 20'h00;
   localparam logic [19:0] AddrRiseEn = 20'h04;
   localparam logic [19:0] AddrFallEn = 20'h08;
   localparam logic [19:0] AddrRsts   = 20'h0C;
   localparam logic [19:0] AddrFsts   = 20'h10;
   localparam logic [19:0] AddrState  = 20'h14;
   localparam logic [19:0] AddrCntSel = 20'h18;
   localparam logic [19:0] AddrEvt    = 20'h1C;

   // State
   logic [NP-1:0]  s1_q, s2_q;
   logic [NP-1:0]  stable_q, stable_d;
   logic [NP-1:0]  stable_dly_q;
   logic [DBW-1:0] cnt_q [NP];
   logic [DBW-1:0] cnt_d [NP];
   logic [DBW-1:0] deb_thr_q, deb_thr_d;
   logic [NP-1:0]  rise_en_q, rise_en_d;
   logic [NP-1:0]  fall_en_q, fall_en_d;
   logic [NP-1:0]  rsts_q, rsts_d;
   logic [NP-1:0]  fsts_q, fsts_d;
   logic [SW-1:0]  cnt_sel_q, cnt_sel_d;
   logic [31:0]    evt_q, evt_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           ack_q;
   logic           irq_q;

   logic [19:0]    addr;
   logic [NP-1:0]  rise, fall;
   logic [NP-1:0]  rsts_clr, fsts_clr;
   logic           sel_rise;
   logic           wr_evt;

   // Only the low address bits are decoded and only the low data bits are stored.
   logic unused_bus_bits;
   assign unused_bus_bits = ^{sys_addr[31:20], sys_wdata};

   assign addr = sys_addr[19:0];

   // Debounce: a bit follows s2 only after disagreeing for DEB_THR+1 consecutive compares.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NP; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] >= deb_thr_q) begin
               stable_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DBW'(1);
            end
         end
      end
   end

   assign rise = stable_q & ~stable_dly_q;
   assign fall = ~stable_q & stable_dly_q;

   // Counter source; selections beyond the last pin match nothing, so EVT holds.
   always_comb begin
      sel_rise = 1'b0;
      for (int i = 0; i < NP; i++) begin
         if (32'(cnt_sel_q) == 32'(i)) sel_rise = rise[i];
      end
   end

   // Register writes and clears
   always_comb begin
      deb_thr_d = deb_thr_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      cnt_sel_d = cnt_sel_q;
      rsts_clr  = '0;
      fsts_clr  = '0;
      wr_evt    = 1'b0;
      if (sys_wen) begin
         case (addr)
            AddrDebThr: deb_thr_d = sys_wdata[DBW-1:0];
            AddrRiseEn: rise_en_d = sys_wdata[NP-1:0];
            AddrFallEn: fall_en_d = sys_wdata[NP-1:0];
            AddrRsts:   rsts_clr  = sys_wdata[NP-1:0];
            AddrFsts:   fsts_clr  = sys_wdata[NP-1:0];
            AddrCntSel: cnt_sel_d = sys_wdata[SW-1:0];
            AddrEvt:    wr_evt    = 1'b1;
            default:    ;
         endcase
      end
   end

   // Set takes priority over a same-cycle clear.
   assign rsts_d = (rsts_q & ~rsts_clr) | (rise & rise_en_q);
   assign fsts_d = (fsts_q & ~fsts_clr) | (fall & fall_en_q);

   // Clear beats a same-cycle edge; the counter sticks at all-ones.
   always_comb begin
      evt_d = evt_q;
      if (wr_evt) begin
         evt_d = '0;
      end else if (sel_rise && (evt_q != 32'hFFFF_FFFF)) begin
         evt_d = evt_q + 32'd1;
      end
   end

   // Read mux returns pre-write values; non-reads return 0.
   always_comb begin
      rdata_d = '0;
      if (sys_ren) begin
         case (addr)
            AddrDebThr: rdata_d = 32'(deb_thr_q);
            AddrRiseEn: rdata_d = 32'(rise_en_q);
            AddrFallEn: rdata_d = 32'(fall_en_q);
            AddrRsts:   rdata_d = 32'(rsts_q);
            AddrFsts:   rdata_d = 32'(fsts_q);
            AddrState:  rdata_d = 32'(stable_q);
            AddrCntSel: rdata_d = 32'(cnt_sel_q);
            AddrEvt:    rdata_d = evt_q;
            default:    rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         s1_q         <= '0;
         s2_q         <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         cnt_q        <= '{default: '0};
         deb_thr_q    <= '0;
         rise_en_q    <= '0;
         fall_en_q    <= '0;
         rsts_q       <= '0;
         fsts_q       <= '0;
         cnt_sel_q    <= '0;
         evt_q        <= '0;
         rdata_q      <= '0;
         ack_q        <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         s1_q         <= pin_i;
         s2_q         <= s1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         cnt_q        <= cnt_d;
         deb_thr_q    <= deb_thr_d;
         rise_en_q    <= rise_en_d;
         fall_en_q    <= fall_en_d;
         rsts_q       <= rsts_d;
         fsts_q       <= fsts_d;
         cnt_sel_q    <= cnt_sel_d;
         evt_q        <= evt_d;
         rdata_q      <= rdata_d;
         ack_q        <= sys_wen | sys_ren;
         irq_q        <= (|rsts_q) | (|fsts_q);
      end
   end

   assign pin_o     = stable_q;
   assign irq_o     = irq_q;
   assign sys_rdata = rdata_q;
   assign sys_ack   = ack_q;
   assign sys_err   = 1'b0;

endmodule

// File: tb/tb_exp_in_conditioner.sv
// Directed bench for exp_in_conditioner (DW=8, DBW=16, SW=4). Inputs change on the
// falling edge, outputs are sampled on the falling edge.

module tb_exp_in_conditioner;

   logic        clk;
   logic        rstn;
   logic [15:0] pin_i;
   logic [15:0] pin_o;
   logic        irq;
   logic [31:0] sys_addr;
   logic [31:0] sys_wdata;
   logic        sys_wen;
   logic        sys_ren;
   logic [31:0] sys_rdata;
   logic        sys_err;
   logic        sys_ack;

   int n_assert = 0;
   int n_fail   = 0;

   exp_in_conditioner #(.DW(8), .DBW(16), .SW(4)) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .pin_i     (pin_i),
      .pin_o     (pin_o),
      .irq_o     (irq),
      .sys_addr  (sys_addr),
      .sys_wdata (sys_wdata),
      .sys_wen   (sys_wen),
      .sys_ren   (sys_ren),
      .sys_rdata (sys_rdata),
      .sys_err   (sys_err),
      .sys_ack   (sys_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: observed no finish, required finish before 500000");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the write is sampled.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      sys_addr  = a;
      sys_wdata = d;
      sys_wen   = 1'b1;
      @(negedge clk);
      sys_wen   = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      sys_addr = a;
      sys_ren  = 1'b1;
      @(negedge clk);
      sys_ren  = 1'b0;
      chk(tag, sys_rdata, exp);
   endtask

   task automatic pulse(input int bit_idx);
      pin_i[bit_idx] = 1'b1;
      repeat (2) @(negedge clk);
      pin_i[bit_idx] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rstn      = 1'b0;
      pin_i     = '0;
      sys_addr  = '0;
      sys_wdata = '0;
      sys_wen   = 1'b0;
      sys_ren   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_pin_o", 32'(pin_o), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_ack", 32'(sys_ack), 32'h0);
      chk("rst_rdata", sys_rdata, 32'h0);
      chk("rst_err", 32'(sys_err), 32'h0);

      // DEB_THR=0: three-edge latency
      rstn     = 1'b1;
      pin_i[0] = 1'b1;
      repeat (2) @(negedge clk);
      chk("thr0_edge2", 32'(pin_o), 32'h0);
      @(negedge clk);
      chk("thr0_edge3", 32'(pin_o), 32'h1);
      read_chk("thr0_state", 32'h14, 32'h0001);
      // pin 0 is the default counter source, so that rise was counted
      read_chk("evt_after_pin0", 32'h1C, 32'h1);

      // DEB_THR=10: short glitch filtered, long pulse passed
      bus_write(32'h00, 32'd10);
      bus_write(32'h04, 32'h0008);
      pin_i[3] = 1'b1;
      repeat (8) @(negedge clk);
      pin_i[3] = 1'b0;
      repeat (15) @(negedge clk);
      chk("glitch_pin_o", 32'(pin_o), 32'h0001);
      read_chk("glitch_rsts", 32'h0C, 32'h0);

      pin_i[3] = 1'b1;
      for (int n = 1; n <= 26; n++) begin
         @(negedge clk);
         if (n == 12) pin_i[3] = 1'b0;
         chk($sformatf("pulse12_n%0d", n), 32'(pin_o),
             ((n >= 13) && (n <= 24)) ? 32'h0009 : 32'h0001);
      end
      read_chk("pulse12_rsts", 32'h0C, 32'h0008);
      read_chk("pulse12_fsts", 32'h10, 32'h0);
      bus_write(32'h0C, 32'h0008);

      // Rise status, irq timing, W1C behaviour
      bus_write(32'h00, 32'd0);
      bus_write(32'h04, 32'h0100);
      @(negedge clk);
      chk("irq_idle", 32'(irq), 32'h0);
      pin_i[8] = 1'b1;
      repeat (4) @(negedge clk);
      chk("irq_n4", 32'(irq), 32'h0);
      @(negedge clk);
      chk("irq_n5", 32'(irq), 32'h1);
      read_chk("rsts_pin8", 32'h0C, 32'h0100);
      bus_write(32'h0C, 32'h0);
      read_chk("rsts_w0", 32'h0C, 32'h0100);
      bus_write(32'h0C, 32'h0100);
      chk("irq_after_w1c", 32'(irq), 32'h1);
      @(negedge clk);
      chk("irq_cleared", 32'(irq), 32'h0);
      read_chk("rsts_cleared", 32'h0C, 32'h0);

      bus_write(32'h08, 32'h0100);
      pin_i[8] = 1'b0;
      repeat (6) @(negedge clk);
      read_chk("fsts_pin8", 32'h10, 32'h0100);
      read_chk("rsts_after_fall", 32'h0C, 32'h0);
      // Rise lands in RSTS on the same edge the W1C is sampled: set wins
      pin_i[8] = 1'b1;
      repeat (3) @(negedge clk);
      bus_write(32'h0C, 32'h0100);
      read_chk("rsts_set_wins", 32'h0C, 32'h0100);
      bus_write(32'h0C, 32'h0100);
      bus_write(32'h10, 32'h0100);
      repeat (2) @(negedge clk);
      chk("irq_all_clear", 32'(irq), 32'h0);

      // Event counter
      bus_write(32'h1C, 32'h0);
      bus_write(32'h18, 32'd5);
      read_chk("cnt_sel", 32'h18, 32'h5);
      for (int p = 0; p < 7; p++) pulse(5);
      repeat (4) @(negedge clk);
      read_chk("evt_7", 32'h1C, 32'h7);
      read_chk("evt_rsts_unaff", 32'h0C, 32'h0);
      bus_write(32'h1C, 32'hDEAD_BEEF);
      read_chk("evt_cleared", 32'h1C, 32'h0);
      force dut.evt_q = 32'hFFFF_FFFE;
      #1;
      release dut.evt_q;
      @(negedge clk);
      read_chk("evt_preset", 32'h1C, 32'hFFFF_FFFE);
      for (int p = 0; p < 3; p++) pulse(5);
      repeat (4) @(negedge clk);
      read_chk("evt_saturate", 32'h1C, 32'hFFFF_FFFF);

      // Unmapped read and back-to-back write/read
      sys_addr = 32'h40;
      sys_ren  = 1'b1;
      @(negedge clk);
      sys_ren  = 1'b0;
      chk("unmap_ack", 32'(sys_ack), 32'h1);
      chk("unmap_rdata", sys_rdata, 32'h0);
      chk("unmap_err", 32'(sys_err), 32'h0);
      sys_addr  = 32'h00;
      sys_wdata = 32'h1234;
      sys_wen   = 1'b1;
      @(negedge clk);
      sys_wen   = 1'b0;
      sys_ren   = 1'b1;
      @(negedge clk);
      sys_ren   = 1'b0;
      chk("b2b_rdata", sys_rdata, 32'h0000_1234);
      chk("b2b_ack", 32'(sys_ack), 32'h1);
      @(negedge clk);
      chk("idle_ack", 32'(sys_ack), 32'h0);

      // Reset mid-debounce with status pending
      bus_write(32'h00, 32'd0);
      bus_write(32'h04, 32'h0002);
      pin_i[1] = 1'b1;
      repeat (6) @(negedge clk);
      chk("pre_rst_irq", 32'(irq), 32'h1);
      bus_write(32'h00, 32'd10);
      pin_i[2] = 1'b1;
      repeat (4) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("mid_rst_pin_o", 32'(pin_o), 32'h0);
      chk("mid_rst_irq", 32'(irq), 32'h0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_n2", 32'(pin_o), 32'h0);
      @(negedge clk);
      chk("post_rst_n3", 32'(pin_o), 32'h0107);
      repeat (2) @(negedge clk);
      read_chk("post_rst_rsts", 32'h0C, 32'h0);
      read_chk("post_rst_fsts", 32'h10, 32'h0);
      read_chk("post_rst_thr", 32'h00, 32'h0);
      // EVT restarted from 0 and caught the pin-0 rise as the debounced state rebuilt
      read_chk("post_rst_evt", 32'h1C, 32'h1);
      chk("post_rst_irq", 32'(irq), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
